// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port VRAM arbiter between display prefetch FIFO and CPU writes
// Ports: sys_clk/vga_rst_n clock and async active-low reset; frame_start flushes;
//   pix_pop/pix_data/pix_valid/underflow display side; cpu_req/cpu_addr/cpu_wdata/cpu_ack
//   CPU write side; vram_en/vram_we/vram_addr/vram_wdata/vram_rdata synchronous VRAM.
module vga_fb_arbiter #(
  parameter int FB_WORDS   = 19200,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 8
) (
  input  logic        sys_clk,
  input  logic        vga_rst_n,
  input  logic        frame_start,
  input  logic        pix_pop,
  output logic [11:0] pix_data,
  output logic        pix_valid,
  output logic        underflow,
  input  logic        cpu_req,
  input  logic [14:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        vram_en,
  output logic        vram_we,
  output logic [14:0] vram_addr,
  output logic [11:0] vram_wdata,
  input  logic [11:0] vram_rdata
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LWM = (CW+1)'(LOW_WM);
  localparam logic [CW:0] FDP = (CW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, READ, WRITE, FLUSH} state_t;
  state_t r_state;
  state_t w_next;
  logic [14:0]   r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_pend;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [11:0]   r_mem [FIFO_DEPTH];
  logic [CW:0]   w_level;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_nxt;
  logic [AW-1:0] w_head_nxt;
  logic [14:0]   w_rd_nxt;
  logic [11:0]   w_pix_nxt;
  // A read occupies two cycles before it lands: issued (state READ) then returning (r_pend).
  // Both count against capacity so the FIFO can never be over-committed.
  assign w_level    = (CW+1)'(r_count) + (CW+1)'(r_state == READ) + (CW+1)'(r_pend);
  assign w_push     = r_pend & ~frame_start;
  assign w_pop      = pix_pop & (r_count != '0) & ~frame_start;
  assign w_cnt_nxt  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_head_nxt = r_head + AW'(w_pop);
  assign w_rd_nxt   = (r_rd_ptr == 15'(FB_WORDS - 1)) ? '0 : r_rd_ptr + 15'd1;
  // cpu_ack high means a write was granted last cycle; skipping one cycle avoids a
  // double write while the requester is still dropping cpu_req.
  assign w_next = frame_start              ? FLUSH :
                  (w_level < LWM)          ? READ  :
                  (cpu_req && !cpu_ack)    ? WRITE :
                  (w_level < FDP)          ? READ  : IDLE;
  // Head register: when the FIFO drains to only the arriving word, bypass the memory.
  assign w_pix_nxt = (frame_start || w_cnt_nxt == '0) ? '0 :
                     (r_count == CW'(w_pop))          ? vram_rdata : r_mem[w_head_nxt];
  assign pix_valid = (r_count != '0);
  always_ff @(posedge sys_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_state    <= IDLE;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pend     <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      pix_data   <= '0;
      underflow  <= 1'b0;
      cpu_ack    <= 1'b0;
      vram_en    <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
    end else begin
      r_state    <= w_next;
      vram_en    <= (w_next == READ) || (w_next == WRITE);
      vram_we    <= (w_next == WRITE);
      cpu_ack    <= (w_next == WRITE);
      vram_addr  <= (w_next == READ) ? r_rd_ptr : (w_next == WRITE) ? cpu_addr : vram_addr;
      vram_wdata <= (w_next == WRITE) ? cpu_wdata : vram_wdata;
      r_rd_ptr   <= frame_start ? '0 : (w_next == READ) ? w_rd_nxt : r_rd_ptr;
      r_pend     <= (r_state == READ) & ~frame_start;
      r_count    <= frame_start ? '0 : w_cnt_nxt;
      r_head     <= frame_start ? '0 : w_head_nxt;
      r_tail     <= frame_start ? '0 : r_tail + AW'(w_push);
      pix_data   <= w_pix_nxt;
      underflow  <= underflow | (pix_pop & (r_count == '0) & ~frame_start);
    end
  end
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_tail] <= vram_rdata;
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed scoreboard bench for vga_fb_arbiter
module tb_vga_fb_arbiter;
  localparam int FB = 19200;
  logic        sys_clk = 1'b0;
  logic        vga_rst_n;
  logic        frame_start, pix_pop, cpu_req;
  logic [14:0] cpu_addr;
  logic [11:0] cpu_wdata;
  logic [11:0] pix_data, vram_wdata, vram_rdata;
  logic        pix_valid, underflow, cpu_ack, vram_en, vram_we;
  logic [14:0] vram_addr;
  int checks = 0;
  int fails = 0;
  int acks;
  logic [27:0] exp_q[$];

  vga_fb_arbiter dut (
    .sys_clk(sys_clk), .vga_rst_n(vga_rst_n), .frame_start(frame_start), .pix_pop(pix_pop),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [11:0] pat(input int a);
    return 12'(a * 13 + 5);
  endfunction

  always @(posedge sys_clk) vram_rdata <= (vram_en && !vram_we) ? pat(int'(vram_addr)) : 12'h000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic exp_rd(input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 15'((first + i) % FB), 12'h000});
  endtask

  task automatic exp_wr(input logic [14:0] a, input logic [11:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic wait_ack(input int budget);
    acks = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cpu_ack) begin
        acks++;
        cpu_req = 1'b0;
      end
    end
  endtask

  always @(negedge sys_clk) begin
    if (vga_rst_n && vram_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $error("FAIL vram_extra_op observed=%h expected=none", {vram_we, vram_addr, vram_wdata});
      end else begin
        chk("vram_op", {4'h0, vram_we, vram_addr, vram_we ? vram_wdata : 12'h000}, {4'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vga_rst_n = 1'b1; frame_start = 0; pix_pop = 0; cpu_req = 0; cpu_addr = '0; cpu_wdata = '0;
    #3 vga_rst_n = 1'b0;
    #1;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_vram_en", vram_en, 0);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_vram_wdata", vram_wdata, 0);
    tick(); tick();
    // fill: 16 reads at 0..15, first pixel visible on cycle 3
    exp_rd(0, 16);
    vga_rst_n = 1'b1;
    tick();
    chk("fill_first_en", vram_en, 1);
    chk("fill_first_addr", vram_addr, 0);
    tick();
    chk("fill_valid_c2", pix_valid, 0);
    tick();
    chk("fill_valid_c3", pix_valid, 1);
    chk("fill_head", pix_data, pat(0));
    repeat (20) tick();
    chk("fill_reads_done", exp_q.size(), 0);
    chk("fill_idle_en", vram_en, 0);
    // CPU write with a full FIFO
    exp_wr(15'h1234, 12'hABC);
    cpu_req = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 12'hABC;
    wait_ack(12);
    chk("wr_ack_pulses", acks, 1);
    chk("wr_done", exp_q.size(), 0);
    // flush with CPU request held: reads win until level 8, then the write
    exp_rd(0, 8);
    exp_wr(15'h0042, 12'h123);
    exp_rd(8, 8);
    cpu_req = 1'b1; cpu_addr = 15'h0042; cpu_wdata = 12'h123; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("wm_flush_empty", pix_valid, 0);
    wait_ack(40);
    chk("wm_ack_pulses", acks, 1);
    chk("wm_seq_done", exp_q.size(), 0);
    chk("wm_idle_en", vram_en, 0);
    // continuous drain across the frame wrap
    exp_rd(16, FB);
    for (int k = 0; k < FB; k++) begin
      chk("drain_valid", pix_valid, 1);
      chk("drain_data", pix_data, pat(k));
      pix_pop = 1'b1;
      tick();
    end
    pix_pop = 1'b0;
    repeat (20) tick();
    chk("drain_underflow", underflow, 0);
    chk("drain_reads_done", exp_q.size(), 0);
    // flush during an outstanding read: word 16 is dropped, refill restarts at 0
    exp_rd(16, 1);
    exp_rd(0, 16);
    pix_pop = 1'b1;
    tick();
    pix_pop = 1'b0;
    for (int i = 0; i < 10 && !vram_en; i++) tick();
    chk("fl_read_seen", vram_en, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("fl_empty", pix_valid, 0);
    repeat (25) tick();
    chk("fl_head_addr0", pix_data, pat(0));
    chk("fl_full", pix_valid, 1);
    chk("fl_reads_done", exp_q.size(), 0);
    // pop with frame_start is ignored; pop on empty sets sticky underflow
    exp_rd(0, 16);
    frame_start = 1'b1; pix_pop = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("uf_flush_pop_ignored", underflow, 0);
    tick();
    pix_pop = 1'b0;
    chk("uf_set", underflow, 1);
    chk("uf_pix_zero", pix_data, 0);
    repeat (25) tick();
    chk("uf_sticky", underflow, 1);
    chk("uf_fifo_untouched", pix_data, pat(0));
    chk("uf_reads_done", exp_q.size(), 0);
    // reset before a pending write is granted; request re-served after resume
    cpu_req = 1'b1; cpu_addr = 15'h7FFF; cpu_wdata = 12'h555;
    #2 vga_rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mr_ack_low", cpu_ack, 0);
    chk("mr_en_low", vram_en, 0);
    chk("mr_underflow_clr", underflow, 0);
    chk("mr_valid_clr", pix_valid, 0);
    tick(); tick();
    exp_rd(0, 8);
    exp_wr(15'h7FFF, 12'h555);
    exp_rd(8, 8);
    vga_rst_n = 1'b1;
    tick();
    chk("mr_resume_en", vram_en, 1);
    chk("mr_resume_addr", vram_addr, 0);
    wait_ack(40);
    chk("mr_ack_pulses", acks, 1);
    chk("mr_seq_done", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL provide parameter FB_WORDS, default 19200, giving the number of 12-bit framebuffer words per frame.
REQ-002 The block SHALL provide parameter FIFO_DEPTH, default 16, giving the pixel prefetch FIFO depth (power of two).
REQ-003 The block SHALL provide parameter LOW_WM, default 8, giving the FIFO low watermark.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port sys_clk, input, 1 bit: clock. All logic is on its rising edge.
REQ-005 The block SHALL have port vga_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse at start of vertical sync.
REQ-007 The block SHALL have port pix_pop, input, 1 bit: display consumes the head pixel.
REQ-008 The block SHALL have port pix_data, output, 12 bits: FIFO head pixel (RGB444).
REQ-009 The block SHALL have port pix_valid, output, 1 bit: FIFO non-empty.
REQ-010 The block SHALL have port underflow, output, 1 bit: sticky flag, pop while empty.
REQ-011 The block SHALL have port cpu_req, input, 1 bit: CPU write request, held until ack.
REQ-012 The block SHALL have port cpu_addr, input, 15 bits: CPU write address.
REQ-013 The block SHALL have port cpu_wdata, input, 12 bits: CPU write data.
REQ-014 The block SHALL have port cpu_ack, output, 1 bit: one-cycle pulse, write performed.
REQ-015 The block SHALL have ports vram_en, output, 1 bit; vram_we, output, 1 bit; vram_addr, output, 15 bits; vram_wdata, output, 12 bits: single-port VRAM control.
REQ-016 The block SHALL have port vram_rdata, input, 12 bits: VRAM read data, valid exactly 1 cycle after a read issue.

Function
REQ-017 Grant FSM states SHALL be IDLE, READ, WRITE and FLUSH; the state is registered and is re-evaluated every cycle.
REQ-018 Priority, highest first:
  1. frame_start SHALL force FLUSH.
  2. Otherwise, if (fifo_count + inflight) < LOW_WM, the FSM SHALL select READ.
  3. Otherwise, if cpu_req=1 and no cpu_ack was issued in the previous cycle, the FSM SHALL select WRITE.
  4. Otherwise, if (fifo_count + inflight) < FIFO_DEPTH, the FSM SHALL select READ.
  5. Otherwise, the FSM SHALL select IDLE.
REQ-019 READ SHALL drive vram_en=1, vram_we=0 and vram_addr=rd_ptr, set inflight=1 for one cycle, and increment rd_ptr, wrapping from FB_WORDS-1 to 0.
REQ-020 vram_rdata SHALL be pushed into the FIFO in the cycle after a READ, unless a FLUSH occurred in between, in which case the data is discarded.
REQ-021 WRITE SHALL drive vram_en=1, vram_we=1, vram_addr=cpu_addr and vram_wdata=cpu_wdata, and assert cpu_ack in that same cycle.
REQ-022 IDLE and FLUSH SHALL drive vram_en=0 and vram_we=0.
REQ-023 FLUSH SHALL set rd_ptr=0, empty the FIFO, drop in-flight data and leave underflow unchanged, taking 1 cycle.
REQ-024 A simultaneous push and pop SHALL leave fifo_count unchanged, and the FIFO SHALL never overflow; overflow prevention is guaranteed by the inflight accounting in REQ-018.
REQ-025 pix_data SHALL be the registered FIFO head; pix_valid=(fifo_count!=0).
REQ-026 A pop with pix_valid=0 SHALL set underflow=1, leave the FIFO untouched, and drive pix_data=0.
REQ-027 A pop and frame_start in the same cycle SHALL be resolved with FLUSH winning; the pop is ignored.
REQ-028 A CPU write SHALL be serviced within LOW_WM+2 cycles of cpu_req once the FIFO is at or above LOW_WM.
REQ-029 cpu_addr values >= FB_WORDS SHALL be passed through unchecked.

Reset
REQ-030 Assertion of vga_rst_n=0 SHALL asynchronously force:
  - state=IDLE, rd_ptr=0, fifo_count=0, inflight=0
  - pix_valid=0, pix_data=0, underflow=0, cpu_ack=0
  - vram_en=0, vram_we=0, vram_addr=0, vram_wdata=0
REQ-031 Reset asserted mid-operation SHALL abandon an in-progress write without asserting cpu_ack; the requester must re-request.
REQ-032 Operation SHALL resume at the first rising sys_clk edge after deassertion.

Verification
REQ-033 Fill test: release reset with no pops and no cpu_req -> 16 consecutive reads at addresses 0..15, then vram_en=0; pix_valid=1 from cycle 3.
REQ-034 CPU write under a full FIFO: cpu_req with addr 0x1234 and data 0xABC -> one write cycle with vram_we=1, vram_addr=0x1234 and vram_wdata=0xABC, plus a single cpu_ack pulse.
REQ-035 Watermark priority: with fifo_count=7 and cpu_req held, the next grant is READ; WRITE occurs once the count reaches 8.
REQ-036 Wrap: drain continuously for 19200 pops -> rd_ptr wraps to 0 after address 19199, and no underflow occurs.
REQ-037 Flush: frame_start during a READ -> the returned word is dropped, the FIFO is emptied, and the next read is at address 0.
REQ-038 Underflow: pop with the FIFO empty -> underflow=1 sticky until reset, and pix_data=0.
